// File: rtl/pp_pipeline_accel_fifo_srl_stat_if.sv
// Handshake bundle for the pipeline-accel SRL channel FIFO.
// The master drives data and requests, and the slave (the FIFO) returns status.
interface pp_pipeline_accel_fifo_srl_stat_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  logic                  if_flush;
  logic                  if_stat_clr;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_write;
  logic                  if_write_ce;
  logic                  if_full_n;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_read;
  logic                  if_read_ce;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   if_num_data_valid;
  logic [ADDR_WIDTH:0]   if_fifo_cap;
  logic                  if_almost_full;
  logic                  if_almost_empty;
  logic                  if_overflow;
  logic                  if_underflow;
  logic [ADDR_WIDTH:0]   if_high_water;

  modport master (
    output if_flush, if_stat_clr, if_din, if_write, if_write_ce, if_read, if_read_ce,
    input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap,
           if_almost_full, if_almost_empty, if_overflow, if_underflow, if_high_water
  );

  modport slave (
    input  if_flush, if_stat_clr, if_din, if_write, if_write_ce, if_read, if_read_ce,
    output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap,
           if_almost_full, if_almost_empty, if_overflow, if_underflow, if_high_water
  );
endinterface

// File: rtl/pp_pipeline_accel_fifo_srl_stat.sv
// Shift-register FWFT FIFO with registered almost flags, flush, sticky error flags
// and a high-water mark. The read pointer is -1 when empty and indexes the oldest word.
module pp_pipeline_accel_fifo_srl_stat #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 2,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input logic clk,
  input logic reset,
  pp_pipeline_accel_fifo_srl_stat_if.slave fifo_if
);
  localparam logic [ADDR_WIDTH:0] CAP       = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] EMPTY_PTR = '1;

  logic [DATA_WIDTH-1:0] srl [DEPTH];
  logic [ADDR_WIDTH:0]   ptr, ptr_nxt, lvl_nxt;
  logic                  empty_n_r, full_n_r, afull_r, aempty_r, ovf_r, udf_r;
  logic [ADDR_WIDTH:0]   hw_r;
  logic                  wr_req, rd_req, wr, rd, ovf_set, udf_set;

  assign wr_req = fifo_if.if_write & fifo_if.if_write_ce;
  assign rd_req = fifo_if.if_read  & fifo_if.if_read_ce;
  // Flush kills both transfers and suppresses error detection in its cycle.
  assign wr      = wr_req & full_n_r  & ~fifo_if.if_flush;
  assign rd      = rd_req & empty_n_r & ~fifo_if.if_flush;
  assign ovf_set = wr_req & ~full_n_r  & ~fifo_if.if_flush;
  assign udf_set = rd_req & ~empty_n_r & ~fifo_if.if_flush;

  always_comb begin
    ptr_nxt = ptr;
    if (fifo_if.if_flush)  ptr_nxt = EMPTY_PTR;
    else if (rd && !wr)    ptr_nxt = ptr - ONE;
    else if (wr && !rd)    ptr_nxt = ptr + ONE;
    lvl_nxt = ptr_nxt + ONE;
  end

  // Storage carries no reset; validity is tracked entirely by ptr.
  always_ff @(posedge clk) begin
    if (wr) begin
      srl[0] <= fifo_if.if_din;
      for (int i = 1; i < DEPTH; i++) srl[i] <= srl[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= EMPTY_PTR;
      empty_n_r <= 1'b0;
      full_n_r  <= 1'b1;
      afull_r   <= 1'b0;
      aempty_r  <= 1'b1;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
      hw_r      <= '0;
    end else begin
      ptr       <= ptr_nxt;
      empty_n_r <= (lvl_nxt != '0);
      full_n_r  <= (lvl_nxt != CAP);
      afull_r   <= (lvl_nxt >= AF_LVL);
      aempty_r  <= (lvl_nxt <= AE_LVL);
      ovf_r     <= ovf_set | (ovf_r & ~fifo_if.if_stat_clr);
      udf_r     <= udf_set | (udf_r & ~fifo_if.if_stat_clr);
      if (fifo_if.if_stat_clr || lvl_nxt > hw_r) hw_r <= lvl_nxt;
    end
  end

  assign fifo_if.if_dout           = ptr[ADDR_WIDTH] ? srl[0] : srl[ptr[ADDR_WIDTH-1:0]];
  assign fifo_if.if_empty_n        = empty_n_r;
  assign fifo_if.if_full_n         = full_n_r;
  assign fifo_if.if_num_data_valid = ptr + ONE;
  assign fifo_if.if_fifo_cap       = CAP;
  assign fifo_if.if_almost_full    = afull_r;
  assign fifo_if.if_almost_empty   = aempty_r;
  assign fifo_if.if_overflow       = ovf_r;
  assign fifo_if.if_underflow      = udf_r;
  assign fifo_if.if_high_water     = hw_r;
endmodule

// File: tb/tb_pp_pipeline_accel_fifo_srl_stat.sv
// Directed bench for the SRL stat FIFO at DEPTH=4, AF=3, AE=1.
module tb_pp_pipeline_accel_fifo_srl_stat;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pp_pipeline_accel_fifo_srl_stat_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus ();

  pp_pipeline_accel_fifo_srl_stat #(
    .DATA_WIDTH(32), .ADDR_WIDTH(2), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) dut (
    .clk(clk), .reset(reset), .fifo_if(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_flush = 0; bus.if_stat_clr = 0; bus.if_din = '0;
    bus.if_write = 0; bus.if_write_ce = 0; bus.if_read = 0; bus.if_read_ce = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".empty_n"}, 32'(bus.if_empty_n), 0);
    chk({tag, ".full_n"},  32'(bus.if_full_n), 1);
    chk({tag, ".level"},   32'(bus.if_num_data_valid), 0);
    chk({tag, ".aempty"},  32'(bus.if_almost_empty), 1);
    chk({tag, ".afull"},   32'(bus.if_almost_full), 0);
    chk({tag, ".ovf"},     32'(bus.if_overflow), 0);
    chk({tag, ".udf"},     32'(bus.if_underflow), 0);
    chk({tag, ".hw"},      32'(bus.if_high_water), 0);
    chk({tag, ".cap"},     32'(bus.if_fifo_cap), 4);
  endtask

  task automatic push(input logic [31:0] d);
    bus.if_din = d; bus.if_write = 1; bus.if_write_ce = 1;
    step();
    bus.if_write = 0; bus.if_write_ce = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    chk_reset_vals("rst");

    // Fill A0..A3 back to back
    for (int i = 0; i < 4; i++) begin
      bus.if_din = 32'hA0 + 32'(i); bus.if_write = 1; bus.if_write_ce = 1;
      step();
      chk($sformatf("fill%0d.level", i), 32'(bus.if_num_data_valid), 32'(i + 1));
      chk($sformatf("fill%0d.afull", i), 32'(bus.if_almost_full), (i >= 2) ? 1 : 0);
      chk($sformatf("fill%0d.full_n", i), 32'(bus.if_full_n), (i == 3) ? 0 : 1);
    end
    idle();
    chk("fill.hw", 32'(bus.if_high_water), 4);
    chk("fill.dout", bus.if_dout, 32'hA0);
    chk("fill.empty_n", 32'(bus.if_empty_n), 1);

    // Full: read+write together, write dropped and flagged
    bus.if_read = 1; bus.if_read_ce = 1;
    bus.if_write = 1; bus.if_write_ce = 1; bus.if_din = 32'hB0;
    step();
    idle();
    chk("ovf.flag", 32'(bus.if_overflow), 1);
    chk("ovf.level", 32'(bus.if_num_data_valid), 3);
    chk("ovf.dout", bus.if_dout, 32'hA1);
    chk("ovf.full_n", 32'(bus.if_full_n), 1);

    // Drain remaining three
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain%0d.dout", i), bus.if_dout, 32'hA0 + 32'(i));
      bus.if_read = 1; bus.if_read_ce = 1;
      step();
      chk($sformatf("drain%0d.aempty", i), 32'(bus.if_almost_empty), ((3 - i) <= 1) ? 1 : 0);
    end
    idle();
    chk("drain.empty_n", 32'(bus.if_empty_n), 0);
    chk("drain.level", 32'(bus.if_num_data_valid), 0);

    // Underflow then stat clear
    bus.if_read = 1; bus.if_read_ce = 1;
    step();
    idle();
    chk("udf.flag", 32'(bus.if_underflow), 1);
    chk("udf.level", 32'(bus.if_num_data_valid), 0);
    bus.if_stat_clr = 1;
    step();
    idle();
    chk("clr.udf", 32'(bus.if_underflow), 0);
    chk("clr.ovf", 32'(bus.if_overflow), 0);
    chk("clr.hw", 32'(bus.if_high_water), 0);

    // Streaming at level 2
    push(32'hD0);
    push(32'hD1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("strm%0d.dout", i), bus.if_dout, 32'hD0 + 32'(i));
      bus.if_read = 1; bus.if_read_ce = 1;
      bus.if_write = 1; bus.if_write_ce = 1; bus.if_din = 32'hD2 + 32'(i);
      step();
      chk($sformatf("strm%0d.level", i), 32'(bus.if_num_data_valid), 2);
      chk($sformatf("strm%0d.flags", i),
          {28'd0, bus.if_empty_n, bus.if_full_n, bus.if_almost_full, bus.if_almost_empty},
          32'b1100);
    end
    idle();
    chk("strm.dout", bus.if_dout, 32'hDA);
    chk("strm.hw", 32'(bus.if_high_water), 2);

    // Flush at level 3 with a concurrent write
    push(32'hE0);
    chk("pre_flush.level", 32'(bus.if_num_data_valid), 3);
    bus.if_flush = 1; bus.if_write = 1; bus.if_write_ce = 1; bus.if_din = 32'hEE;
    step();
    idle();
    chk("flush.level", 32'(bus.if_num_data_valid), 0);
    chk("flush.empty_n", 32'(bus.if_empty_n), 0);
    chk("flush.full_n", 32'(bus.if_full_n), 1);
    chk("flush.aempty", 32'(bus.if_almost_empty), 1);
    chk("flush.afull", 32'(bus.if_almost_full), 0);
    chk("flush.ovf", 32'(bus.if_overflow), 0);
    chk("flush.hw", 32'(bus.if_high_water), 3);
    push(32'hC5);
    chk("post_flush.dout", bus.if_dout, 32'hC5);
    chk("post_flush.empty_n", 32'(bus.if_empty_n), 1);
    chk("post_flush.level", 32'(bus.if_num_data_valid), 1);

    // Reset mid-burst at level 2
    push(32'hC6);
    chk("pre_rst.level", 32'(bus.if_num_data_valid), 2);
    reset = 1; bus.if_write = 1; bus.if_write_ce = 1; bus.if_din = 32'hC7;
    step();
    idle();
    reset = 0;
    chk_reset_vals("mid_rst");
    push(32'hF1);
    push(32'hF2);
    chk("after_rst.dout0", bus.if_dout, 32'hF1);
    bus.if_read = 1; bus.if_read_ce = 1;
    step();
    idle();
    chk("after_rst.dout1", bus.if_dout, 32'hF2);
    chk("after_rst.level", 32'(bus.if_num_data_valid), 1);
    chk("after_rst.hw", 32'(bus.if_high_water), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
